// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press/release/short/long/repeat events
// and queues SHORT/LONG/REPEAT codes in a one-entry valid/ack register. Auto-repeat: BUTTON_AUTO_REPEAT_EN.
module button_event_decoder #(
    parameter int unsigned LONG_PRESS_TIME = 100_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter int unsigned CNT_W           = 27
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       button_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       held,
    output logic       repeat_pulse,
    output logic       event_valid,
    output logic [1:0] event_code,
    input  logic       event_ack,
    output logic       event_overflow
);

    if (LONG_PRESS_TIME < 2) begin : g_bad_long
        $error("LONG_PRESS_TIME must be >= 2");
    end
    if (REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("REPEAT_PERIOD must be >= 2");
    end

    localparam logic [1:0]       CODE_NONE  = 2'b00;
    localparam logic [1:0]       CODE_SHORT = 2'b01;
    localparam logic [1:0]       CODE_LONG  = 2'b10;
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_PRESS_TIME - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [1:0]       CODE_REPEAT = 2'b11;
    localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             press_d, release_d, short_d, long_d, held_d;
    logic             post;
    logic [1:0]       post_code;
    logic             valid_d, ovf_d;
    logic [1:0]       code_d;
`ifdef BUTTON_AUTO_REPEAT_EN
    logic             repeat_d;
`endif

    // Next-state, pulse and event-register logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        post      = 1'b0;
        post_code = CODE_NONE;
`ifdef BUTTON_AUTO_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (button_level && !prev_q) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                // Release takes priority over reaching the long threshold
                if (!button_level) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    post      = 1'b1;
                    post_code = CODE_SHORT;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d    = 1'b1;
                    post      = 1'b1;
                    post_code = CODE_LONG;
                    cnt_d     = '0;
                    state_d   = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!button_level) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (cnt_q == REP_LAST) begin
                    repeat_d  = 1'b1;
                    post      = 1'b1;
                    post_code = CODE_REPEAT;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        held_d = (state_d == ST_HELD);

        valid_d = event_valid;
        code_d  = event_code;
        ovf_d   = event_overflow;
        if (post) begin
            if (!event_valid || event_ack) begin
                valid_d = 1'b1;
                code_d  = post_code;
                ovf_d   = 1'b0;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (event_ack && event_valid) begin
            valid_d = 1'b0;
            code_d  = CODE_NONE;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            prev_q         <= 1'b0;
            press_pulse    <= 1'b0;
            release_pulse  <= 1'b0;
            short_press    <= 1'b0;
            long_press     <= 1'b0;
            held           <= 1'b0;
            event_valid    <= 1'b0;
            event_code     <= CODE_NONE;
            event_overflow <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prev_q         <= button_level;
            press_pulse    <= press_d;
            release_pulse  <= release_d;
            short_press    <= short_d;
            long_press     <= long_d;
            held           <= held_d;
            event_valid    <= valid_d;
            event_code     <= code_d;
            event_overflow <= ovf_d;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    always_ff @(posedge CLK) begin
        if (RESET) repeat_pulse <= 1'b0;
        else       repeat_pulse <= repeat_d;
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: a press-duration reference model
// queues the expected output vector per cycle; a monitor pops and compares.
module tb_button_event_decoder;

    localparam int unsigned LPT = 8;
    localparam int unsigned RP  = 4;
    localparam int unsigned CW  = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       button_level = 1'b0;
    logic       event_ack = 1'b0;
    logic       press_pulse, release_pulse, short_press, long_press, held, repeat_pulse;
    logic       event_valid, event_overflow;
    logic [1:0] event_code;

    always #5 CLK = ~CLK;

    button_event_decoder #(
        .LONG_PRESS_TIME(LPT),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .button_level  (button_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .held          (held),
        .repeat_pulse  (repeat_pulse),
        .event_valid   (event_valid),
        .event_code    (event_code),
        .event_ack     (event_ack),
        .event_overflow(event_overflow)
    );

    // {press, release, short, long, held, repeat, valid, code[1:0], overflow}
    typedef logic [9:0] vec_t;
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: tracks how many edges the button has been down since its press
    bit         m_pressed = 0;
    bit         m_prev    = 0;
    int         m_dur     = 0;
    bit         m_valid   = 0;
    bit         m_ovf     = 0;
    logic [1:0] m_code    = 2'b00;

    function automatic vec_t model_step(input logic r, input logic l, input logic a);
        logic       pp = 0, rp = 0, sp = 0, lp = 0, rep = 0, post = 0;
        logic [1:0] pc = 2'b00;
        if (r) begin
            m_pressed = 0; m_prev = 0; m_dur = 0;
            m_valid = 0; m_ovf = 0; m_code = 2'b00;
            return '0;
        end
        if (l && !m_prev) begin
            pp = 1; m_pressed = 1; m_dur = 0;
        end else if (m_pressed) begin
            m_dur++;
            if (!l) begin
                rp = 1;
                m_pressed = 0;
                if (m_dur <= int'(LPT)) begin sp = 1; post = 1; pc = 2'b01; end
            end else if (m_dur == int'(LPT)) begin
                lp = 1; post = 1; pc = 2'b10;
            end else if (AR && m_dur > int'(LPT) && ((m_dur - int'(LPT)) % int'(RP)) == 0) begin
                rep = 1; post = 1; pc = 2'b11;
            end
        end
        m_prev = l;
        if (post) begin
            if (!m_valid || a) begin m_valid = 1; m_code = pc; m_ovf = 0; end
            else m_ovf = 1;
        end else if (a && m_valid) begin
            m_valid = 0; m_code = 2'b00; m_ovf = 0;
        end
        return {pp, rp, sp, lp, (m_pressed && m_dur >= int'(LPT)), rep, m_valid, m_code, m_ovf};
    endfunction

    task automatic step(input logic r, input logic l, input logic a);
        @(negedge CLK);
        RESET        = r;
        button_level = l;
        event_ack    = a;
        cyc++;
        exp_q.push_back(model_step(r, l, a));
    endtask

    task automatic press(input int n, input int ack_at);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, logic'(i == ack_at));
    endtask

    task automatic idle(input int n, input logic a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, a);
    endtask

    // Monitor: compares the registered outputs just after each active edge
    initial begin
        vec_t e, act;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {press_pulse, release_pulse, short_press, long_press, held,
                       repeat_pulse, event_valid, event_code, event_overflow};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d t=%0t got=%b expected=%b (pp rp sp lp held rep vld code ovf)",
                             cyc, $time, act, e);
                end
            end
        end
    end

    initial begin
        // Reset with button low
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        // Short press then ack
        press(3, -1);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        // Long press then ack
        press(12, -1);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        // Long hold with repeats, ack mid-hold
        press(21, 13);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        // Release exactly at the long threshold: short wins
        press(8, -1);
        idle(1, 1'b1);
        idle(2, 1'b0);
        // Two shorts unacked, third short with same-cycle ack
        press(2, -1); idle(2, 1'b0);
        press(2, -1); idle(2, 1'b0);
        press(2, -1); step(1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(1, 1'b1);
        // Ack with nothing pending
        idle(2, 1'b1);
        // Reset during HELD with button kept high
        press(10, -1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        press(12, -1);
        idle(2, 1'b0);
        idle(1, 1'b1);
        // Randomized presses, acks and occasional resets
        for (int p = 0; p < 60; p++) begin
            int len, gap;
            len = int'($urandom_range(1, 26));
            gap = int'($urandom_range(1, 5));
            for (int i = 0; i < len; i++)
                step(logic'($urandom_range(0, 79) == 0), 1'b1, logic'($urandom_range(0, 3) == 0));
            for (int i = 0; i < gap; i++)
                step(1'b0, 1'b0, logic'($urandom_range(0, 3) == 0));
        end
        idle(2, 1'b0);
        repeat (3) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes a debounced, active-high button level and classifies it into discrete events: press, release, short press, long press and optional auto-repeat.
- Presents the classified event to the coprocessor control logic through a one-entry valid/ack event register with overflow flagging.
- Sits directly downstream of the button debouncer on the same clock.

Parameters:
- LONG_PRESS_TIME, 100_000_000, cycles a press must last, counted from the cycle press_pulse is asserted, to become a long press; must be >= 2.
- REPEAT_PERIOD, 10_000_000, cycles between auto-repeat events while held; must be >= 2.
- CNT_W, 27, counter width; must hold max(LONG_PRESS_TIME, REPEAT_PERIOD) - 1.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- button_level  input  1  debounced button level, 1 = pressed; already synchronous to CLK.
- press_pulse  output  1  one-cycle pulse on a 0->1 transition of button_level.
- release_pulse  output  1  one-cycle pulse on a 1->0 transition of button_level.
- short_press  output  1  one-cycle pulse when a release occurs before the long threshold.
- long_press  output  1  one-cycle pulse when the long threshold is reached.
- held  output  1  level, high while in HELD.
- repeat_pulse  output  1  one-cycle pulse per auto-repeat; tied 0 without AUTO_REPEAT_EN.
- event_valid  output  1  event register holds an unread event.
- event_code  output  2  01 SHORT, 10 LONG, 11 REPEAT, 00 none.
- event_ack  input  1  consumer accepts the event; meaningful only when event_valid = 1.
- event_overflow  output  1  an event was dropped while event_valid = 1.

Behaviour:
- Reset (synchronous): state IDLE, counter 0, prev_level 0, all outputs 0, event_code 00.
- Edge detection uses a registered prev_level. Because prev_level resets to 0, a button held through reset produces press_pulse on the first cycle after reset.
- All outputs are registered. Each pulse appears one cycle after the rising edge at which its condition is sampled, and lasts exactly 1 cycle.
- FSM states: IDLE, PRESSED, HELD.
- IDLE:
  - rising edge -> press_pulse, counter <= 0, go to PRESSED.
  - otherwise stay in IDLE.
- PRESSED: counter increments every cycle.
  - button_level = 0 -> release_pulse and short_press together, post SHORT, go to IDLE.
  - else if counter == LONG_PRESS_TIME-1 -> long_press, held <= 1, post LONG, counter <= 0, go to HELD.
  - If the release and the threshold fall in the same cycle, the release wins (SHORT).
- HELD:
  - button_level = 0 -> release_pulse, held <= 0, go to IDLE. No short_press is generated.
  - with AUTO_REPEAT_EN: counter increments; at REPEAT_PERIOD-1 -> repeat_pulse, post REPEAT, counter <= 0.
  - A release in the same cycle as the repeat threshold: release wins, no repeat is posted.
- Counter never wraps; it is cleared on every state change.
- Event register:
  - post while event_valid = 0 -> load code, event_valid <= 1.
  - event_ack while valid with no post -> event_valid <= 0, event_code <= 00, event_overflow <= 0.
  - post and ack in the same cycle -> load the new code, event_valid stays 1, event_overflow <= 0.
  - post while valid with no ack -> new event dropped, old code kept, event_overflow <= 1 (sticky until ack or reset).
  - event_ack while event_valid = 0 -> ignored.
- Press/release pulses are not posted to the event register; they are direct outputs only.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: HELD runs the repeat counter and generates repeat_pulse and REPEAT events as above.
- Undefined: the repeat counter logic is absent, repeat_pulse is constant 0, code 11 is never produced, and HELD only waits for release.

Test Plan:
All scenarios use LONG_PRESS_TIME=8 and REPEAT_PERIOD=4.
- Hold RESET for 3 cycles with button_level=0 -> every output is 0 and event_code=00.
- Press for 3 cycles then release -> press_pulse 1 cycle; on release, release_pulse and short_press in the same cycle; event_valid=1, code=01; held never rises.
- Press for 12 cycles then release -> long_press pulses exactly 8 cycles after press_pulse; held=1 until the release; release_pulse with no short_press; code=10.
- With the macro defined, press for 8+13 cycles -> 3 repeat_pulse, 4 cycles apart. The first REPEAT is dropped (LONG still unacked) and event_overflow=1. Ack then gives valid=0, overflow=0, and later repeats load code 11.
- Two short presses with no ack -> code stays 01, overflow=1. Ack in the same cycle as a third SHORT -> valid stays 1, code=01, overflow=0.
- Assert RESET during HELD with the button kept high -> held=0, valid=0. Deassert -> press_pulse next cycle, then long_press 8 cycles later.
